data_sram_like_responder: RTL and testbench
===========================================

// Module: data_sram_like_responder
// PURPOSE
//  Responder (slave) end of the CPU data-side SRAM-like interface that the pipeline's
//  MEM stage drives (data_req) and WB stage completes (data_data_ok / data_rdata).
//  Accepts load/store requests, queues them in order, and answers each after a fixed latency.
//  Used as the on-chip data memory model and as the template for the AXI bridge front end.
//  Returns full aligned words on reads; the WB stage does byte/half extraction and sign extension.
// PARAMETERS
//  DEPTH_LOG2   10  log2 of memory depth in 32-bit words; word index = data_addr[DEPTH_LOG2+1:2]
//  LATENCY      2   cycles from request acceptance to data_ok; legal range 1..15
//  OUTSTANDING  2   max accepted-but-unanswered requests (queue depth); legal range 1..8
// PORTS
//  clk          in   1   clock; all logic is on the posedge
//  resetn       in   1   synchronous reset, active-low
//  data_req     in   1   request valid
//  data_wr      in   1   1 = store, 0 = load
//  data_size    in   2   0 = byte, 1 = half, 2 = word, 3 = treated as word
//  data_addr    in   32  byte address; bits above DEPTH_LOG2+1 are ignored
//  data_wdata   in   32  store data, already lane-aligned by the initiator
//  data_addr_ok out  1   request accepted on this edge when data_req && data_addr_ok
//  data_data_ok out  1   one-cycle pulse per accepted request, in acceptance order
//  data_rdata   out  32  full word at the head entry's word index; valid only while data_data_ok=1
// BEHAVIOUR
//  Reset: queue flushed (count=0), addr_ok=0, data_ok=0 while resetn=0; memory array not reset.
//  - A request arriving during reset is never accepted.
//  Acceptance: data_addr_ok = resetn && (count < OUTSTANDING).
//  - Purely count-based; no same-cycle full-and-dequeue bypass.
//  Queue entry fields: wr, word index, wdata, strobe[3:0], countdown[3:0].
//  - countdown is loaded with LATENCY-1 on enqueue.
//  - Every valid entry's countdown decrements each cycle while >0.
//  Strobe from size/addr[1:0]:
//  - byte: 4'b0001 << addr[1:0]
//  - half: addr[1] ? 4'b1100 : 4'b0011 (addr[0] ignored)
//  - word/3: 4'b1111 (addr[1:0] ignored)
//  Response: data_ok = head valid && head countdown==0.
//  - Request accepted at edge T gives data_ok in cycle T+LATENCY (cycle after edge T is T+1).
//  - Back-to-back accepts give back-to-back data_ok pulses.
//  - No backpressure: the initiator must take data_ok/rdata in that cycle.
//  - Loads: data_rdata = mem[head.index], combinational, with no forwarding needed.
//  - Stores: byte lanes with strobe=1 are written at the edge that ends the data_ok cycle.
//    rdata on a store response shows the pre-write word; the initiator ignores it.
//  - Head pops on that same edge. Enqueue and pop in the same edge: count unchanged.
//  Ordering: stores commit in order, so a load accepted after a store to the same word returns
//  the updated word.
//  Pointers: head/tail wrap modulo OUTSTANDING; count has width $clog2(OUTSTANDING+1).
//  Reset mid-operation:
//  - All pending entries are discarded with no data_ok.
//  - Uncommitted stores are never written.
//  - A store whose data_ok edge coincides with resetn=0 is not committed.
// TESTING (defaults unless noted)
//  1 Reset: resetn=0 for 3 cycles with data_req=1
//    -> addr_ok=0, data_ok=0 throughout; no data_ok at any time after release.
//  2 sw 0x12345678 @0x100, then lw @0x100 on the next cycle
//    -> data_ok in cycles T+2 and T+3; load rdata=0x12345678.
//  3 Then sb wdata=0xAB000000 @0x103, then lw @0x100 -> rdata=0xAB345678.
//  4 Then sh wdata=0x0000BEEF @0x101 (addr[0] ignored), then lw @0x100 -> rdata=0xAB34BEEF.
//  5 OUTSTANDING=2, data_req held 4 cycles
//    -> addr_ok low after 2 accepts, high again after first data_ok; exactly 4 data_ok, in order.
//  6 Two outstanding sw, resetn=0 for 1 cycle before either data_ok
//    -> no data_ok; a later lw of those addresses returns the old contents.

Source files
------------

// File: rtl/data_sram_like_responder.sv
// Responder end of the CPU data-side SRAM-like interface: in-order request queue,
// fixed-latency responses, and a byte-writable word memory behind it.
module data_sram_like_responder #(
  parameter int DEPTH_LOG2  = 10,
  parameter int LATENCY     = 2,
  parameter int OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(OUTSTANDING + 1);
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [31:0]           mem_q     [DEPTH];

  logic                  q_vld_q   [OUTSTANDING];
  logic                  q_wr_q    [OUTSTANDING];
  logic [DEPTH_LOG2-1:0] q_idx_q   [OUTSTANDING];
  logic [31:0]           q_wdata_q [OUTSTANDING];
  logic [3:0]            q_strb_q  [OUTSTANDING];
  logic [3:0]            q_cnt_q   [OUTSTANDING];

  logic [PTR_W-1:0]      head_q, head_d;
  logic [PTR_W-1:0]      tail_q, tail_d;
  logic [CNT_W-1:0]      count_q, count_d;

  logic                  accept;
  logic                  pop;
  logic                  mem_we;
  logic [3:0]            strb_new;
  logic [3:0]            byte_we;
  logic [DEPTH_LOG2-1:0] idx_new;
  logic                  unused_addr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(OUTSTANDING - 1)) ? '0 : p + 1'b1;
  endfunction

  assign idx_new     = data_addr[DEPTH_LOG2+1:2];
  assign unused_addr = ^data_addr[31:DEPTH_LOG2+2];

  always_comb begin
    strb_new = 4'b1111;
    case (data_size)
      2'd0:    strb_new = 4'b0001 << data_addr[1:0];
      2'd1:    strb_new = data_addr[1] ? 4'b1100 : 4'b0011;
      default: strb_new = 4'b1111;
    endcase
  end

  // Acceptance is purely count-based: a pop in the same cycle does not free a slot early.
  assign data_addr_ok = resetn && (count_q < CNT_W'(OUTSTANDING));
  assign data_data_ok = resetn && q_vld_q[head_q] && (q_cnt_q[head_q] == 4'd0);
  assign data_rdata   = mem_q[q_idx_q[head_q]];

  assign accept = data_req && data_addr_ok;
  assign pop    = data_data_ok;
  assign mem_we = pop && q_wr_q[head_q];

  always_comb begin
    head_d  = pop    ? ptr_inc(head_q) : head_q;
    tail_d  = accept ? ptr_inc(tail_q) : tail_q;
    count_d = count_q;
    case ({accept, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < OUTSTANDING; i++) q_vld_q[i] <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      for (int i = 0; i < OUTSTANDING; i++) begin
        if (accept && (tail_q == PTR_W'(i))) begin
          q_vld_q[i]   <= 1'b1;
          q_wr_q[i]    <= data_wr;
          q_idx_q[i]   <= idx_new;
          q_wdata_q[i] <= data_wdata;
          q_strb_q[i]  <= strb_new;
          q_cnt_q[i]   <= 4'(LATENCY - 1);
        end else if (pop && (head_q == PTR_W'(i))) begin
          q_vld_q[i] <= 1'b0;
        end else if (q_vld_q[i] && (q_cnt_q[i] != 4'd0)) begin
          q_cnt_q[i] <= q_cnt_q[i] - 4'd1;
        end
      end
    end
  end

  // pop is already gated by resetn, so a store answering on a reset edge never commits.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_byte_we
      assign byte_we[gi] = mem_we && q_strb_q[head_q][gi];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (byte_we[b]) mem_q[q_idx_q[head_q]][8*b +: 8] <= q_wdata_q[head_q][8*b +: 8];
    end
  end

endmodule

// File: tb/tb_data_sram_like_responder.sv
// Directed self-checking bench for data_sram_like_responder with default parameters.
module tb_data_sram_like_responder;

  logic        clk;
  logic        resetn;
  logic        data_req;
  logic        data_wr;
  logic [1:0]  data_size;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_addr_ok;
  logic        data_data_ok;
  logic [31:0] data_rdata;

  int vectors;
  int miscompares;

  data_sram_like_responder dut (
    .clk          (clk),
    .resetn       (resetn),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // One request cycle; the slot must be free.
  task automatic issue(input string tag, input logic wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    data_req   = 1'b1;
    data_wr    = wr;
    data_size  = size;
    data_addr  = addr;
    data_wdata = wdata;
    #1;
    chk({tag, "_addr_ok"}, {31'd0, data_addr_ok}, 32'd1);
    $display("issue %s wr=%0d size=%0d addr=%08h wdata=%08h", tag, wr, size, addr, wdata);
    tick();
  endtask

  task automatic resp(input string tag, input logic chk_rd, input logic [31:0] exp_rd);
    data_req = 1'b0;
    #1;
    chk({tag, "_data_ok"}, {31'd0, data_data_ok}, 32'd1);
    if (chk_rd) chk({tag, "_rdata"}, data_rdata, exp_rd);
    $display("resp  %s data_ok=%0d rdata=%08h", tag, data_data_ok, data_rdata);
    tick();
  endtask

  task automatic idle(input string tag);
    data_req = 1'b0;
    #1;
    chk({tag, "_idle_data_ok"}, {31'd0, data_data_ok}, 32'd0);
    tick();
  endtask

  // Store then load of the same word on consecutive cycles.
  task automatic st_ld(input string tag, input logic [1:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] exp_rd);
    issue({tag, "_st"}, 1'b1, size, addr, wdata);
    issue({tag, "_ld"}, 1'b0, 2'd2, {addr[31:2], 2'b00}, 32'd0);
    resp({tag, "_st"}, 1'b0, 32'd0);
    resp({tag, "_ld"}, 1'b1, exp_rd);
    idle(tag);
  endtask

  // Held-request table for the back-pressure sequence.
  logic        h_req  [8] = '{1, 1, 1, 1, 1, 0, 0, 0};
  logic        h_wr   [8] = '{1, 1, 0, 0, 0, 0, 0, 0};
  logic [31:0] h_addr [8] = '{32'h104, 32'h108, 32'h104, 32'h104, 32'h108, 0, 0, 0};
  logic [31:0] h_wd   [8] = '{32'hCAFE0001, 32'hCAFE0002, 0, 0, 0, 0, 0, 0};
  logic        e_aok  [8] = '{1, 1, 0, 1, 1, 0, 1, 1};
  logic        e_dok  [8] = '{0, 0, 1, 1, 0, 1, 1, 0};
  logic        e_chkrd[8] = '{0, 0, 0, 0, 0, 1, 1, 0};
  logic [31:0] e_rd   [8] = '{0, 0, 0, 0, 0, 32'hCAFE0001, 32'hCAFE0002, 0};

  initial begin
    vectors     = 0;
    miscompares = 0;
    resetn      = 1'b0;
    data_req    = 1'b1;
    data_wr     = 1'b0;
    data_size   = 2'd2;
    data_addr   = 32'h100;
    data_wdata  = 32'd0;

    // Reset held with a pending request.
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("rst_addr_ok", {31'd0, data_addr_ok}, 32'd0);
      chk("rst_data_ok", {31'd0, data_data_ok}, 32'd0);
      $display("reset cycle %0d addr_ok=%0d data_ok=%0d", c, data_addr_ok, data_data_ok);
    end
    resetn   = 1'b1;
    data_req = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("post_rst_addr_ok", {31'd0, data_addr_ok}, 32'd1);
      idle("post_rst");
    end

    st_ld("sw_lw", 2'd2, 32'h100, 32'h12345678, 32'h12345678);
    st_ld("sb_lw", 2'd0, 32'h103, 32'hAB000000, 32'hAB345678);
    st_ld("sh_lw", 2'd1, 32'h101, 32'h0000BEEF, 32'hAB34BEEF);

    // Request held until accepted with two outstanding slots.
    for (int c = 0; c < 8; c++) begin
      data_req   = h_req[c];
      data_wr    = h_wr[c];
      data_size  = 2'd2;
      data_addr  = h_addr[c];
      data_wdata = h_wd[c];
      #1;
      chk($sformatf("hold_c%0d_addr_ok", c), {31'd0, data_addr_ok}, {31'd0, e_aok[c]});
      chk($sformatf("hold_c%0d_data_ok", c), {31'd0, data_data_ok}, {31'd0, e_dok[c]});
      if (e_chkrd[c]) chk($sformatf("hold_c%0d_rdata", c), data_rdata, e_rd[c]);
      $display("hold cycle %0d req=%0d addr_ok=%0d data_ok=%0d rdata=%08h",
               c, data_req, data_addr_ok, data_data_ok, data_rdata);
      tick();
    end

    // Reset while two stores are outstanding: neither may commit.
    st_ld("pre200", 2'd2, 32'h200, 32'h11112222, 32'h11112222);
    st_ld("pre204", 2'd2, 32'h204, 32'h33334444, 32'h33334444);
    issue("rst_sw0", 1'b1, 2'd2, 32'h200, 32'hDEAD0000);
    issue("rst_sw1", 1'b1, 2'd2, 32'h204, 32'hDEAD0001);
    resetn   = 1'b0;
    data_req = 1'b0;
    #1;
    chk("midrst_data_ok", {31'd0, data_data_ok}, 32'd0);
    chk("midrst_addr_ok", {31'd0, data_addr_ok}, 32'd0);
    $display("mid-op reset data_ok=%0d addr_ok=%0d", data_data_ok, data_addr_ok);
    tick();
    resetn = 1'b1;
    for (int c = 0; c < 4; c++) idle("after_midrst");
    issue("old_ld0", 1'b0, 2'd2, 32'h200, 32'd0);
    issue("old_ld1", 1'b0, 2'd2, 32'h204, 32'd0);
    resp("old_ld0", 1'b1, 32'h11112222);
    resp("old_ld1", 1'b1, 32'h33334444);
    idle("final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
